waveform_loader: RTL and testbench

Serial word receiver that fills the DAC playback waveform memory. It deserializes 16-bit words from the host's SPI-style link (sclk/mosi framed by cs_n) into the single `clk` domain. It presents each completed word as `data_store` with a one-cycle write strobe and a sequential write address. It sits upstream of the playback block; that block reads the memory back out to the DAC.

---
 rtl/waveform_loader_pkg.sv | 14 +
 rtl/waveform_loader_if.sv | 35 +++
 rtl/sync_2ff.sv | 22 ++
 rtl/waveform_loader.sv | 167 ++++++++++++++++
 tb/tb_waveform_loader.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/waveform_loader_pkg.sv
// Shared defaults and FSM encoding for the waveform loader.
// No logic of its own; imported by the loader interface and top.
package waveform_loader_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DEPTH  = 65535;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/waveform_loader_if.sv
// Store-side and serial-link signals of the waveform loader, grouped as one bundle.
// master is the loader itself; slave is the host link plus the memory/status consumer.
interface waveform_loader_if
    import waveform_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              clear;
    logic [DATA_W-1:0] data_store;
    logic              store_valid;
    logic [ADDR_W-1:0] store_addr;
    logic              full;
    logic              overflow;
    logic              frame_err;
    logic              frame_done;
    logic [ADDR_W-1:0] frame_words;

    modport master (
        input  sclk, cs_n, mosi, clear,
        output data_store, store_valid, store_addr, full,
               overflow, frame_err, frame_done, frame_words
    );

    modport slave (
        output sclk, cs_n, mosi, clear,
        input  data_store, store_valid, store_addr, full,
               overflow, frame_err, frame_done, frame_words
    );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer; 2 clk latency, no backpressure.
// Resets low so a line already low at reset exit never looks like a falling edge.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/waveform_loader.sv
// Deserializes host serial words into sequential waveform-memory writes; store strobe 1 clk after final-bit detect.
// No backpressure: words arriving while full are dropped and flagged in overflow.
module waveform_loader
    import waveform_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    waveform_loader_if.master bus
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    logic sclk_s, cs_s, mosi_s;
    logic sclk_q, cs_q, mosi_q;
    logic sclk_rise, cs_fall, cs_rise;

    state_t state, state_nxt;

    logic [DATA_W-1:0] shift_q, shift_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] frame_cnt, frame_cnt_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic              shift_en, word_done, end_frame, part_err;
    logic              full;

    logic [DATA_W-1:0] data_store_q;
    logic [ADDR_W-1:0] store_addr_q, frame_words_q;
    logic              store_valid_q, overflow_q, frame_err_q, frame_done_q;

    sync_2ff u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(bus.sclk), .q(sclk_s));
    sync_2ff u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(bus.cs_n), .q(cs_s));
    sync_2ff u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(bus.mosi), .q(mosi_s));

    // Edge pulses are registered; mosi is delayed alongside so it lines up with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q    <= 1'b0;
            cs_q      <= 1'b0;
            mosi_q    <= 1'b0;
            sclk_rise <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
        end else begin
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
            mosi_q    <= mosi_s;
            sclk_rise <= sclk_s & ~sclk_q;
            cs_fall   <= ~cs_s & cs_q;
            cs_rise   <= cs_s & ~cs_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = SHIFT;
            SHIFT:   if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A final bit landing together with cs_n rise still completes and is counted.
    always_comb begin
        shift_en      = 1'b0;
        word_done     = 1'b0;
        end_frame     = 1'b0;
        part_err      = 1'b0;
        shift_nxt     = {shift_q[DATA_W-2:0], mosi_q};
        frame_cnt_nxt = frame_cnt;
        if (state == SHIFT) begin
            shift_en  = sclk_rise;
            word_done = sclk_rise && (bit_cnt == LAST_BIT);
            end_frame = cs_rise;
            part_err  = cs_rise && !word_done && (sclk_rise || (bit_cnt != '0));
            if (word_done && !(&frame_cnt)) begin
                frame_cnt_nxt = frame_cnt + 1'b1;
            end
        end
    end

    assign full = (wr_addr == DEPTH_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            if (shift_en) begin
                shift_q <= shift_nxt;
            end
            if ((state == IDLE) || word_done) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if ((state == IDLE) && cs_fall) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt_nxt;
            end
        end
    end

    // clear outranks the post-store increment so a same-cycle clear rewinds to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr       <= '0;
            store_valid_q <= 1'b0;
            data_store_q  <= '0;
            store_addr_q  <= '0;
            overflow_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_words_q <= '0;
        end else begin
            store_valid_q <= word_done && !full;
            if (word_done && !full) begin
                data_store_q <= shift_nxt;
                store_addr_q <= wr_addr;
            end
            if (bus.clear) begin
                wr_addr <= '0;
            end else if (store_valid_q) begin
                wr_addr <= wr_addr + 1'b1;
            end
            if (bus.clear) begin
                overflow_q <= 1'b0;
            end else if (word_done && full) begin
                overflow_q <= 1'b1;
            end
            if (bus.clear) begin
                frame_err_q <= 1'b0;
            end else if (part_err) begin
                frame_err_q <= 1'b1;
            end
            frame_done_q <= end_frame;
            if (end_frame) begin
                frame_words_q <= frame_cnt_nxt;
            end
        end
    end

    assign bus.data_store  = data_store_q;
    assign bus.store_valid = store_valid_q;
    assign bus.store_addr  = store_addr_q;
    assign bus.full        = full;
    assign bus.overflow    = overflow_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_words = frame_words_q;

endmodule

// File: tb/tb_waveform_loader.sv
// Bench for waveform_loader: two instances (default depth and depth 4) share one host link;
// a scoreboard holds expected stores and frame counts, monitors pop and compare on the strobes.
module tb_waveform_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    waveform_loader_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
    waveform_loader_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();

    assign bus0.sclk = sclk;
    assign bus0.cs_n = cs_n;
    assign bus0.mosi = mosi;
    assign bus0.clear = clear;
    assign bus1.sclk = sclk;
    assign bus1.cs_n = cs_n;
    assign bus1.mosi = mosi;
    assign bus1.clear = clear;

    waveform_loader #(.DATA_W(16), .ADDR_W(16), .DEPTH(65535)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    waveform_loader #(.DATA_W(16), .ADDR_W(16), .DEPTH(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_assert = 0;
    int n_fail = 0;

    // scoreboard: {addr, data} per store, frame_words per frame
    logic [31:0] sq0[$];
    logic [31:0] sq1[$];
    logic [15:0] fq0[$];
    logic [15:0] fq1[$];
    int n_sv0 = 0;
    int n_fd0 = 0;

    // reference model of the host-visible behaviour
    int          depth_m[2] = '{65535, 4};
    int          wr_m[2] = '{0, 0};
    bit          ovf_m[2] = '{1'b0, 1'b0};
    bit          err_m = 1'b0;
    bit          m_active = 1'b0;
    int          m_bits = 0;
    logic [15:0] m_shift = '0;
    int          m_fcnt = 0;

    bit prev_sv0 = 1'b0;
    bit prev_sv1 = 1'b0;

    always @(negedge clk) begin
        logic [31:0] e;
        logic [15:0] f;
        if (rst_n) begin
            if (bus0.store_valid) begin
                n_sv0++;
                n_assert++;
                if (sq0.size() == 0) begin
                    n_fail++;
                    $display("FAIL store0_unexpected got addr=%0d data=%h required no store",
                             bus0.store_addr, bus0.data_store);
                end else begin
                    e = sq0.pop_front();
                    if ({bus0.store_addr, bus0.data_store} !== e) begin
                        n_fail++;
                        $display("FAIL store0 got addr=%0d data=%h required addr=%0d data=%h",
                                 bus0.store_addr, bus0.data_store, e[31:16], e[15:0]);
                    end
                end
                n_assert++;
                if (prev_sv0) begin
                    n_fail++;
                    $display("FAIL store0_back_to_back got 2 consecutive strobes required 1");
                end
            end
            if (bus1.store_valid) begin
                n_assert++;
                if (sq1.size() == 0) begin
                    n_fail++;
                    $display("FAIL store1_unexpected got addr=%0d data=%h required no store",
                             bus1.store_addr, bus1.data_store);
                end else begin
                    e = sq1.pop_front();
                    if ({bus1.store_addr, bus1.data_store} !== e) begin
                        n_fail++;
                        $display("FAIL store1 got addr=%0d data=%h required addr=%0d data=%h",
                                 bus1.store_addr, bus1.data_store, e[31:16], e[15:0]);
                    end
                end
            end
            if (bus0.frame_done) begin
                n_fd0++;
                n_assert++;
                if (fq0.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame0_unexpected got frame_done words=%0d required none",
                             bus0.frame_words);
                end else begin
                    f = fq0.pop_front();
                    if (bus0.frame_words !== f) begin
                        n_fail++;
                        $display("FAIL frame0_words got %0d required %0d", bus0.frame_words, f);
                    end
                end
            end
            if (bus1.frame_done) begin
                n_assert++;
                if (fq1.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame1_unexpected got frame_done words=%0d required none",
                             bus1.frame_words);
                end else begin
                    f = fq1.pop_front();
                    if (bus1.frame_words !== f) begin
                        n_fail++;
                        $display("FAIL frame1_words got %0d required %0d", bus1.frame_words, f);
                    end
                end
            end
        end
        prev_sv0 = bus0.store_valid;
        prev_sv1 = bus1.store_valid;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_word(input logic [15:0] w);
        if (m_fcnt < 65535) m_fcnt++;
        for (int k = 0; k < 2; k++) begin
            if (wr_m[k] < depth_m[k]) begin
                if (k == 0) sq0.push_back({16'(wr_m[k]), w});
                else        sq1.push_back({16'(wr_m[k]), w});
                wr_m[k]++;
            end else begin
                ovf_m[k] = 1'b1;
            end
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            wr_m[k] = 0;
            ovf_m[k] = 1'b0;
        end
        err_m = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit clr_on_store);
        int t;
        mosi = b;
        wait_clk(4);
        sclk = 1'b1;
        if (m_active) begin
            m_shift = {m_shift[14:0], b};
            m_bits++;
            if (m_bits == 16) begin
                m_bits = 0;
                model_word(m_shift);
            end
        end
        if (clr_on_store) begin
            t = 0;
            while (!bus0.store_valid && t < 12) begin
                @(negedge clk);
                t++;
            end
            n_assert++;
            if (!bus0.store_valid) begin
                n_fail++;
                $display("FAIL clear_align got no store_valid in 12 clk required a strobe");
            end
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            model_clear();
            wait_clk(2);
        end else begin
            wait_clk(5);
        end
        sclk = 1'b0;
        wait_clk(5);
    endtask

    task automatic send_word(input logic [15:0] w, input bit clr_on_store);
        for (int i = 15; i >= 0; i--) begin
            send_bit(w[i], clr_on_store && (i == 0));
        end
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        m_active = 1'b1;
        m_fcnt = 0;
        m_bits = 0;
        wait_clk(6);
    endtask

    task automatic frame_end();
        cs_n = 1'b1;
        if (m_active) begin
            fq0.push_back(16'(m_fcnt));
            fq1.push_back(16'(m_fcnt));
            if (m_bits != 0) err_m = 1'b1;
        end
        m_active = 1'b0;
        m_bits = 0;
        wait_clk(8);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_active = 1'b0;
        m_bits = 0;
        model_clear();
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
    endtask

    task automatic check_drained(input string tag);
        n_assert++;
        if (sq0.size() + sq1.size() + fq0.size() + fq1.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained got %0d/%0d stores %0d/%0d frames pending required 0",
                     tag, sq0.size(), sq1.size(), fq0.size(), fq1.size());
        end
    endtask

    task automatic test_reset();
        wait_clk(2);
        n_assert++;
        if (bus0.data_store !== 16'h0 || bus0.store_addr !== 16'h0 || bus0.frame_words !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_buses got data=%h addr=%h words=%h required 0/0/0",
                     bus0.data_store, bus0.store_addr, bus0.frame_words);
        end
        n_assert++;
        if ({bus0.store_valid, bus0.full, bus0.overflow, bus0.frame_err, bus0.frame_done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags got sv/full/ovf/err/done=%b required 00000",
                     {bus0.store_valid, bus0.full, bus0.overflow, bus0.frame_err, bus0.frame_done});
        end
        n_assert++;
        if (bus1.full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_full1 got %b required 0", bus1.full);
        end
        rst_n = 1'b1;
        wait_clk(3);
    endtask

    task automatic test_frame();
        do_reset();
        frame_start();
        send_word(16'h5555, 1'b0);
        send_word(16'hAAAA, 1'b0);
        send_word(16'h0000, 1'b0);
        frame_end();
        check_drained("frame");
        n_assert++;
        if (bus0.frame_err !== err_m) begin
            n_fail++;
            $display("FAIL frame_err got %b required %b", bus0.frame_err, err_m);
        end
        n_assert++;
        if (bus0.frame_words !== 16'd3 || bus0.store_addr !== 16'd2) begin
            n_fail++;
            $display("FAIL frame_held got words=%0d addr=%0d required 3/2",
                     bus0.frame_words, bus0.store_addr);
        end
    endtask

    task automatic test_partial();
        do_reset();
        frame_start();
        for (int i = 0; i < 9; i++) send_bit(1'(i % 2), 1'b0);
        frame_end();
        n_assert++;
        if (bus0.frame_err !== err_m || bus1.frame_err !== err_m) begin
            n_fail++;
            $display("FAIL partial_err got %b/%b required %b", bus0.frame_err, bus1.frame_err, err_m);
        end
        check_drained("partial");
        frame_start();
        send_word(16'hC3A5, 1'b0);
        frame_end();
        check_drained("partial_next");
        n_assert++;
        if (bus0.store_addr !== 16'd0 || bus0.frame_err !== err_m) begin
            n_fail++;
            $display("FAIL partial_next got addr=%0d err=%b required 0/%b",
                     bus0.store_addr, bus0.frame_err, err_m);
        end
    endtask

    task automatic test_depth();
        do_reset();
        frame_start();
        for (int i = 0; i < 4; i++) send_word(16'h1234, 1'b0);
        n_assert++;
        if (bus1.full !== (wr_m[1] == depth_m[1]) || bus1.overflow !== ovf_m[1] || bus0.full !== 1'b0) begin
            n_fail++;
            $display("FAIL depth_full got full1=%b ovf1=%b full0=%b required %b/%b/0",
                     bus1.full, bus1.overflow, bus0.full, wr_m[1] == depth_m[1], ovf_m[1]);
        end
        send_word(16'h1234, 1'b0);
        n_assert++;
        if (bus1.overflow !== ovf_m[1] || bus0.overflow !== ovf_m[0]) begin
            n_fail++;
            $display("FAIL depth_overflow got ovf1=%b ovf0=%b required %b/%b",
                     bus1.overflow, bus0.overflow, ovf_m[1], ovf_m[0]);
        end
        frame_end();
        check_drained("depth");
    endtask

    // runs on from test_depth: instance 1 is full with overflow set going in
    task automatic test_clear_store();
        frame_start();
        send_word(16'h0F0F, 1'b0);
        send_word(16'hF00F, 1'b1);
        wait_clk(2);
        n_assert++;
        if (bus1.full !== 1'b0 || bus1.overflow !== 1'b0 || bus0.overflow !== 1'b0 || bus0.full !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_flags got full1=%b ovf1=%b full0=%b ovf0=%b required 0000",
                     bus1.full, bus1.overflow, bus0.full, bus0.overflow);
        end
        send_word(16'h7E81, 1'b0);
        frame_end();
        check_drained("clear");
        n_assert++;
        if (bus0.store_addr !== 16'd0 || bus1.store_addr !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_addr got %0d/%0d required 0/0", bus0.store_addr, bus1.store_addr);
        end
    endtask

    task automatic test_reset_midframe();
        int sv_before;
        do_reset();
        frame_start();
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
        sv_before = n_sv0;
        rst_n = 1'b0;
        m_active = 1'b0;
        m_bits = 0;
        model_clear();
        wait_clk(2);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) send_bit(1'(i % 3 == 0), 1'b0);
        n_assert++;
        if (n_sv0 !== sv_before) begin
            n_fail++;
            $display("FAIL reset_mid_strobes got %0d required %0d", n_sv0, sv_before);
        end
        frame_end();
        frame_start();
        send_word(16'hBEEF, 1'b0);
        frame_end();
        check_drained("reset_mid");
        n_assert++;
        if (bus0.store_addr !== 16'd0 || bus0.data_store !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL reset_mid_next got addr=%0d data=%h required 0/beef",
                     bus0.store_addr, bus0.data_store);
        end
    endtask

    task automatic test_idle_sclk();
        int sv_before;
        int fd_before;
        sv_before = n_sv0;
        fd_before = n_fd0;
        for (int i = 0; i < 20; i++) send_bit(1'(i % 2), 1'b0);
        n_assert++;
        if (n_sv0 !== sv_before || n_fd0 !== fd_before) begin
            n_fail++;
            $display("FAIL idle_sclk got strobes=%0d frames=%0d required %0d/%0d",
                     n_sv0, n_fd0, sv_before, fd_before);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_partial();
        test_depth();
        test_clear_store();
        test_reset_midframe();
        test_idle_sclk();
        wait_clk(5);
        check_drained("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
